// File: rtl/gcd_sched_pkg.sv
// Shared definitions for the GCD core scheduler: FSM encoding and width helpers.
package gcd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESPOND = 3'd4
  } state_t;

  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/gcd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  int          cand;
  logic [ID_W-1:0] cand_idx;
  logic        found;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand     = (int'(ptr) + k) % N_REQ;
      cand_idx = ID_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// Round-robin scheduler sharing one subtractive GCD core among N_REQ requesters.
module gcd_scheduler
  import gcd_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*W-1:0]          req_x,
  input  logic [N_REQ*W-1:0]          req_y,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [id_width(N_REQ)-1:0]  rsp_id,
  output logic [W-1:0]                rsp_data,
  output logic                        rsp_err,
  output logic [W-1:0]                core_x,
  output logic [W-1:0]                core_y,
  output logic                        core_start,
  output logic                        core_rst,
  input  logic                        core_done,
  input  logic [W-1:0]                core_result,
  output logic                        busy
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);

  state_t          state, state_nx;
  logic [ID_W-1:0] rr_ptr, id_q, gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic [W-1:0]    x_q, y_q, data_q, acc_x, acc_y;
  logic            err_q;
  logic [CNT_W-1:0] cnt;
  logic            accept, zero_op, timeout_hit;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  // Operand mux driven by the one-hot grant
  always_comb begin
    acc_x = '0;
    acc_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        acc_x = req_x[i*W +: W];
        acc_y = req_y[i*W +: W];
      end
    end
  end

  always_comb begin
    accept      = (state == ST_IDLE) && (|req_valid) && !rst;
    zero_op     = (acc_x == '0) || (acc_y == '0);
    timeout_hit = (state == ST_WAIT) && !core_done && (cnt == CNT_W'(TIMEOUT - 1));
    req_ready   = accept ? gnt : '0;
    core_start  = (state == ST_ISSUE);
    core_rst    = timeout_hit;
    rsp_valid   = (state == ST_RESPOND);
    busy        = (state != ST_IDLE);
    state_nx    = state;
    unique case (state)
      ST_IDLE:    if (accept) state_nx = zero_op ? ST_RESPOND : ST_ISSUE;
      ST_ISSUE:   state_nx = ST_WAIT;
      ST_WAIT: begin
        if (core_done)        state_nx = ST_CAPTURE;
        else if (timeout_hit) state_nx = ST_RESPOND;
      end
      ST_CAPTURE: state_nx = ST_RESPOND;
      ST_RESPOND: if (rsp_ready) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            x_q    <= acc_x;
            y_q    <= acc_y;
            id_q   <= gnt_idx;
            err_q  <= 1'b0;
            // A zero operand never terminates in a subtractive core; x|y is the answer
            data_q <= zero_op ? (acc_x | acc_y) : '0;
          end
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (timeout_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          data_q <= core_result;
          err_q  <= 1'b0;
        end
        ST_RESPOND: begin
          if (rsp_ready)
            rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;
  assign core_x   = x_q;
  assign core_y   = y_q;

endmodule
